// File: rtl/sync_byte_framer.sv
// Sync-byte hunter and byte slicer over an 8-bit serial window, with a 2-entry valid/ready output buffer.
// Optional drop counter port o_ovf_cnt is enabled by defining FRAMER_OVF_CNT_EN.
module sync_byte_framer #(
  parameter logic [7:0]  SYNC      = 8'hA5,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_bit_vld,
  input  logic [7:0] i_win,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_locked,
  output logic       o_sync,
  output logic       o_ovf
`ifdef FRAMER_OVF_CNT_EN
  ,
  output logic [7:0] o_ovf_cnt
`endif
);

  typedef enum logic {HUNT, LOCK} state_t;

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

  state_t     state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] byte_cnt, byte_cnt_nx;
  logic       capture;
  logic       sync_hit;

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       pop;
  logic       push_ok;
  logic       drop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= HUNT;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      byte_cnt <= byte_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    byte_cnt_nx = byte_cnt;
    capture     = 1'b0;
    sync_hit    = 1'b0;
    case (state)
      HUNT: begin
        if (i_bit_vld && (i_win == SYNC)) begin
          state_nx    = LOCK;
          bit_cnt_nx  = '0;
          byte_cnt_nx = '0;
          sync_hit    = 1'b1;
        end
      end
      LOCK: begin
        if (i_bit_vld) begin
          if (bit_cnt != 3'd7) begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end else begin
            capture    = 1'b1;
            bit_cnt_nx = '0;
            // Last byte of the frame leaves LOCK on its own capture edge
            if (byte_cnt == LAST_BYTE) begin
              state_nx    = HUNT;
              byte_cnt_nx = '0;
            end else begin
              byte_cnt_nx = byte_cnt + 8'd1;
            end
          end
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  assign o_locked = (state == LOCK);
  assign o_valid  = (count != 2'd0);
  assign o_data   = mem[rd_ptr];
  assign pop      = o_valid && i_ready;
  // A pop frees the head slot in the same cycle, so a full buffer can still accept
  assign push_ok  = capture && ((count != 2'd2) || pop);
  assign drop     = capture && !push_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      o_sync <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_win;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count  <= count + {1'b0, push_ok} - {1'b0, pop};
      o_sync <= sync_hit;
      o_ovf  <= drop;
    end
  end

`ifdef FRAMER_OVF_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf_cnt <= '0;
    end else if (drop && (o_ovf_cnt != 8'hFF)) begin
      o_ovf_cnt <= o_ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_byte_framer.sv
// Directed bench for sync_byte_framer: a bit-level window model feeds framed streams
// and a negedge monitor logs delivered bytes, sync and drop pulses.
module tb_sync_byte_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_vld;
  logic [7:0] win;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       locked;
  logic       sync;
  logic       ovf;
`ifdef FRAMER_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  always #5 clk = ~clk;

  sync_byte_framer #(
    .SYNC      (8'hA5),
    .FRAME_LEN (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_bit_vld (bit_vld),
    .i_win     (win),
    .i_ready   (ready),
    .o_data    (data),
    .o_valid   (valid),
    .o_locked  (locked),
    .o_sync    (sync),
    .o_ovf     (ovf)
`ifdef FRAMER_OVF_CNT_EN
    ,
    .o_ovf_cnt (ovf_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] pop_q [$];
  int         pop_t [$];
  logic       pop_lk [$];
  int         sync_seen;
  int         ovf_seen;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        pop_q.push_back(data);
        pop_t.push_back(cyc);
        pop_lk.push_back(locked);
      end
      if (sync) sync_seen++;
      if (ovf)  ovf_seen++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    win     = {win[6:0], b};
    bit_vld = 1'b1;
    @(posedge clk); #1;
    bit_vld = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_log();
    pop_q.delete();
    pop_t.delete();
    pop_lk.delete();
    sync_seen = 0;
    ovf_seen  = 0;
  endtask

  task automatic check_pops(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input int n);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check_eq({tag, "_count"}, pop_q.size(), n);
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("%s_byte%0d", tag, k),
               (k < pop_q.size()) ? {24'h0, pop_q[k]} : 32'hDEAD, {24'h0, e[k]});
    end
  endtask

  task automatic check_spacing(input string tag, input int gap_cycles);
    for (int k = 1; k < 4; k++) begin
      check_eq($sformatf("%s_space%0d", tag, k),
               (k < pop_t.size()) ? pop_t[k] - pop_t[k-1] : -1, gap_cycles);
    end
  endtask

  initial begin
    rst     = 1'b1;
    bit_vld = 1'b0;
    win     = 8'h00;
    ready   = 1'b0;
    clear_log();
    @(posedge clk); #1;
    check_eq("rst_valid",  valid,  0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_data",   data,   8'h00);
    check_eq("rst_sync",   sync,   0);
    check_eq("rst_ovf",    ovf,    0);
    rst = 1'b0;
    idle(2);

    // Frame delivery with bits every cycle
    clear_log();
    ready = 1'b1;
    send_byte(8'hA5, 0);
    check_eq("t1_sync_next", sync,   1);
    check_eq("t1_lock_next", locked, 1);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    idle(4);
    check_pops("t1", 8'h12, 8'h34, 8'h56, 8'h78, 4);
    check_spacing("t1", 8);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("t1_lock_at_pop%0d", k),
               (k < pop_lk.size()) ? {31'h0, pop_lk[k]} : 32'hDEAD, (k < 3) ? 1 : 0);
    check_eq("t1_sync_cnt", sync_seen, 1);
    check_eq("t1_unlocked", locked, 0);

    // Sync pattern inside data is treated as data
    clear_log();
    send_byte(8'hA5, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    idle(4);
    check_pops("t2", 8'hA5, 8'h01, 8'h02, 8'h03, 4);
    check_eq("t2_sync_cnt", sync_seen, 1);
    check_eq("t2_unlocked", locked, 0);

    // Gapped bits: one valid bit every third cycle
    clear_log();
    send_byte(8'hA5, 2);
    send_byte(8'h12, 2);
    send_byte(8'h34, 2);
    send_byte(8'h56, 2);
    send_byte(8'h78, 2);
    idle(4);
    check_pops("t3", 8'h12, 8'h34, 8'h56, 8'h78, 4);
    check_spacing("t3", 24);
    check_eq("t3_sync_cnt", sync_seen, 1);

    // Backpressure across a whole frame
    clear_log();
    ready = 1'b0;
    send_byte(8'hA5, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    idle(2);
    check_eq("t4_held_valid", valid, 1);
    check_eq("t4_held_data",  data,  8'h12);
    check_eq("t4_ovf_pulses", ovf_seen, 2);
    check_eq("t4_no_pops",    pop_q.size(), 0);
    check_eq("t4_unlocked",   locked, 0);
`ifdef FRAMER_OVF_CNT_EN
    check_eq("t4_ovf_cnt", ovf_cnt, 2);
`endif
    ready = 1'b1;
    idle(3);
    ready = 1'b0;
    check_pops("t4", 8'h12, 8'h34, 8'h00, 8'h00, 2);
    check_eq("t4_drained", valid, 0);

    // Asynchronous reset in the middle of a frame
    clear_log();
    send_byte(8'hA5, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check_eq("t5_pre_valid",  valid,  1);
    check_eq("t5_pre_locked", locked, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_valid",  valid,  0);
    check_eq("t5_rst_locked", locked, 0);
    check_eq("t5_rst_data",   data,   8'h00);
`ifdef FRAMER_OVF_CNT_EN
    check_eq("t5_rst_ovf_cnt", ovf_cnt, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_eq("t5_still_hunt", locked, 0);
    check_eq("t5_no_sync",    sync_seen, 0);
    send_byte(8'hA5, 0);
    check_eq("t5_relock",      locked, 1);
    check_eq("t5_resync",      sync,   1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
